// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the parameterised register file.
package reg_file_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: index mux, register-0 masking and write forwarding.
module reg_file_read_port #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] regs,
  input  logic [DEPTH-1:0]            busy_bits,
  input  logic [AW-1:0]               rd_addr,
  input  logic                        wr_fwd,
  input  logic [AW-1:0]               wr_addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rdata,
  output logic                        busy
);

  // Busy is never forwarded; only data sees a same-cycle accepted write.
  always_comb begin
    rdata = regs[rd_addr];
    busy  = busy_bits[rd_addr];
    if (ZERO_REG0 && (rd_addr == '0)) begin
      rdata = '0;
      busy  = 1'b0;
    end else if (BYPASS && wr_fwd && (rd_addr == wr_addr)) begin
      rdata = wr_data;
      busy  = busy_bits[rd_addr];
    end else begin
      rdata = regs[rd_addr];
      busy  = busy_bits[rd_addr];
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// Register file with per-register busy (reservation) bits and a sequential clear sweep.
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit BYPASS    = 1'b1,
  parameter bit ZERO_REG0 = 1'b0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic             res_en,
  input  logic [AW-1:0]    res_addr,
  output logic             busy1,
  output logic             busy2,
  input  logic             clr,
  output logic             ready
);

  state_t                       state_r;
  state_t                       next_state_s;
  logic [AW-1:0]                cnt_r;
  logic [DEPTH-1:0][WIDTH-1:0]  regs_r;
  logic [DEPTH-1:0]             busy_r;
  logic                         wr_acc_s;
  logic                         res_acc_s;
  logic                         cnt_last_s;

  // clr wins over same-cycle writes/reserves, and nothing is accepted mid-sweep.
  assign wr_acc_s   = wr_en && (state_r == IDLE) && !clr && !(ZERO_REG0 && (wr_addr == '0));
  assign res_acc_s  = res_en && (state_r == IDLE) && !clr && !(ZERO_REG0 && (res_addr == '0));
  assign cnt_last_s = (cnt_r == AW'(DEPTH - 1));
  assign ready      = (state_r == IDLE);

  // Next-state logic for the IDLE/CLEAR controller.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (clr) next_state_s = CLEAR;
        else     next_state_s = IDLE;
      end
      CLEAR: begin
        if (cnt_last_s) next_state_s = IDLE;
        else            next_state_s = CLEAR;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, sweep counter, storage and busy bits; the reserve is applied after the write so it wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      regs_r  <= '0;
      busy_r  <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == CLEAR) begin
        regs_r[cnt_r] <= '0;
        busy_r[cnt_r] <= 1'b0;
        cnt_r         <= cnt_last_s ? '0 : cnt_r + AW'(1);
      end else begin
        if (wr_acc_s) begin
          regs_r[wr_addr] <= wr_data;
          busy_r[wr_addr] <= 1'b0;
        end
        if (res_acc_s) begin
          busy_r[res_addr] <= 1'b1;
        end
      end
    end
  end

  reg_file_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG0(ZERO_REG0)
  ) u_port1 (
    .regs(regs_r), .busy_bits(busy_r), .rd_addr(rd_addr1),
    .wr_fwd(wr_acc_s), .wr_addr(wr_addr), .wr_data(wr_data),
    .rdata(rdata1), .busy(busy1)
  );

  reg_file_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS), .ZERO_REG0(ZERO_REG0)
  ) u_port2 (
    .regs(regs_r), .busy_bits(busy_r), .rd_addr(rd_addr2),
    .wr_fwd(wr_acc_s), .wr_addr(wr_addr), .wr_data(wr_data),
    .rdata(rdata2), .busy(busy2)
  );

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: three configurations (default, no bypass, zero r0) share one stimulus stream.
module tb_reg_file_param;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset, wr_en, res_en, clr;
  logic [AW-1:0] wr_addr, res_addr, rd_addr1, rd_addr2;
  logic [W-1:0]  wr_data;

  wire [W-1:0] rd1 [3];
  wire [W-1:0] rd2 [3];
  wire         b1  [3];
  wire         b2  [3];
  wire         rdy [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cfg 0 = default, 1 = BYPASS off, 2 = ZERO_REG0 on
  logic [W-1:0] mem [3][D];
  bit           bsy [3][D];
  int           sweep_pos = -1;

  always #5 clk = ~clk;

  reg_file_param #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1), .ZERO_REG0(1'b0)) dut_def (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rdata1(rd1[0]), .rdata2(rd2[0]),
    .res_en(res_en), .res_addr(res_addr), .busy1(b1[0]), .busy2(b2[0]),
    .clr(clr), .ready(rdy[0]));

  reg_file_param #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b0), .ZERO_REG0(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rdata1(rd1[1]), .rdata2(rd2[1]),
    .res_en(res_en), .res_addr(res_addr), .busy1(b1[1]), .busy2(b2[1]),
    .clr(clr), .ready(rdy[1]));

  reg_file_param #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1), .ZERO_REG0(1'b1)) dut_z (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rdata1(rd1[2]), .rdata2(rd2[2]),
    .res_en(res_en), .res_addr(res_addr), .busy1(b1[2]), .busy2(b2[2]),
    .clr(clr), .ready(rdy[2]));

  function automatic void model_edge();
    if (!reset) begin
      for (int c = 0; c < 3; c++)
        for (int a = 0; a < D; a++) begin
          mem[c][a] = '0;
          bsy[c][a] = 1'b0;
        end
      sweep_pos = -1;
    end else if (sweep_pos >= 0) begin
      for (int c = 0; c < 3; c++) begin
        mem[c][sweep_pos] = '0;
        bsy[c][sweep_pos] = 1'b0;
      end
      sweep_pos = (sweep_pos == D - 1) ? -1 : sweep_pos + 1;
    end else if (clr) begin
      sweep_pos = 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        if (wr_en && !(c == 2 && wr_addr == 0)) begin
          mem[c][wr_addr] = wr_data;
          bsy[c][wr_addr] = 1'b0;
        end
        if (res_en && !(c == 2 && res_addr == 0)) bsy[c][res_addr] = 1'b1;
      end
    end
  endfunction

  function automatic logic [W-1:0] exp_rd(input int c, input logic [AW-1:0] a);
    bit acc;
    acc = (sweep_pos < 0) && wr_en && !clr && !(c == 2 && wr_addr == 0);
    if (c == 2 && a == 0) return '0;
    if (c != 1 && acc && a == wr_addr) return wr_data;
    return mem[c][a];
  endfunction

  function automatic logic exp_busy(input int c, input logic [AW-1:0] a);
    if (c == 2 && a == 0) return 1'b0;
    return bsy[c][a];
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; res_en = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; idle_inputs();
    wr_addr = 3'd1; res_addr = 3'd1; wr_data = 32'h0;
    rd_addr1 = 3'd3; rd_addr2 = 3'd6;
    tick(); tick();
    reset = 1'b1; #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (rd1[c] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1 dut%0d: got %h expected 0", c, rd1[c]); end
      n_checks++; if (rd2[c] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata2 dut%0d: got %h expected 0", c, rd2[c]); end
      n_checks++; if (b1[c] !== 1'b0 || b2[c] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b%b expected 00", c, b1[c], b2[c]); end
      n_checks++; if (rdy[c] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b expected 1", c, rdy[c]); end
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'hDEADBEEF; rd_addr1 = 3'd3; rd_addr2 = 3'd3; #1;
    n_checks++; if (rd1[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd1[0]); end
    n_checks++; if (rd1[1] !== 32'h0) begin n_fail++; $display("FAIL nobypass_same_cycle: got %h expected 0", rd1[1]); end
    tick(); wr_en = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (rd1[c] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_after_write dut%0d: got %h expected deadbeef", c, rd1[c]); end
    end
  endtask

  task automatic test_busy();
    res_en = 1'b1; res_addr = 3'd5; rd_addr1 = 3'd5; tick(); res_en = 1'b0; #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (b1[c] !== 1'b1) begin n_fail++; $display("FAIL busy_after_reserve dut%0d: got %b expected 1", c, b1[c]); end
    end
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h11; #1;
    n_checks++; if (b1[0] !== 1'b1) begin n_fail++; $display("FAIL busy_no_bypass: got %b expected 1", b1[0]); end
    tick(); wr_en = 1'b0; #1;
    n_checks++; if (b1[0] !== 1'b0) begin n_fail++; $display("FAIL busy_cleared_by_write: got %b expected 0", b1[0]); end
    wr_en = 1'b1; res_en = 1'b1; wr_addr = 3'd5; res_addr = 3'd5; wr_data = 32'h11; tick(); idle_inputs(); #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (b1[c] !== 1'b1) begin n_fail++; $display("FAIL reserve_wins dut%0d: got %b expected 1", c, b1[c]); end
      n_checks++; if (rd1[c] !== 32'h11) begin n_fail++; $display("FAIL write_with_reserve dut%0d: got %h expected 11", c, rd1[c]); end
    end
  endtask

  task automatic test_clear();
    int low;
    for (int i = 0; i < D; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = W'(i + 1); tick();
    end
    wr_en = 1'b0; res_en = 1'b1; res_addr = 3'd2; tick(); res_en = 1'b0;
    rd_addr1 = 3'd2; rd_addr2 = 3'd7; #1;
    n_checks++; if (b1[0] !== 1'b1 || rd2[0] !== 32'd8) begin n_fail++; $display("FAIL prefill: got busy %b r7 %h expected 1 8", b1[0], rd2[0]); end
    clr = 1'b1; tick(); clr = 1'b0;
    low = 0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (rdy[0]) break;
      low++;
      if (low == 4) begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hAA; end
      else wr_en = 1'b0;
      tick();
    end
    wr_en = 1'b0;
    n_checks++; if (low !== 8) begin n_fail++; $display("FAIL sweep_length: got %0d expected 8", low); end
    for (int a = 0; a < D; a++) begin
      rd_addr1 = AW'(a); rd_addr2 = AW'(a); #1;
      for (int c = 0; c < 3; c++) begin
        n_checks++; if (rd1[c] !== 32'h0 || b1[c] !== 1'b0 || rdy[c] !== 1'b1) begin
          n_fail++; $display("FAIL after_clear dut%0d r%0d: got %h/%b/%b expected 0/0/1", c, a, rd1[c], b1[c], rdy[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_zero_reg0();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'hFF; res_en = 1'b1; res_addr = 3'd0;
    rd_addr1 = 3'd0; rd_addr2 = 3'd0; #1;
    n_checks++; if (rd1[2] !== 32'h0 || b1[2] !== 1'b0) begin n_fail++; $display("FAIL zero_reg0_same_cycle: got %h/%b expected 0/0", rd1[2], b1[2]); end
    n_checks++; if (rd1[0] !== 32'hFF) begin n_fail++; $display("FAIL reg0_bypass_default: got %h expected ff", rd1[0]); end
    tick(); idle_inputs(); #1;
    n_checks++; if (rd1[2] !== 32'h0 || b2[2] !== 1'b0) begin n_fail++; $display("FAIL zero_reg0_after: got %h/%b expected 0/0", rd1[2], b2[2]); end
    n_checks++; if (rd1[0] !== 32'hFF || b1[0] !== 1'b1) begin n_fail++; $display("FAIL reg0_default: got %h/%b expected ff/1", rd1[0], b1[0]); end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < D; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = $urandom | 32'h1; tick();
    end
    wr_en = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0; tick(); reset = 1'b1; #1;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (rdy[c] !== 1'b1) begin n_fail++; $display("FAIL reset_aborts_sweep dut%0d: got %b expected 1", c, rdy[c]); end
    end
    for (int a = 0; a < D; a++) begin
      rd_addr1 = AW'(a); #1;
      for (int c = 0; c < 3; c++) begin
        n_checks++; if (rd1[c] !== 32'h0) begin n_fail++; $display("FAIL reset_mid_sweep_data dut%0d r%0d: got %h expected 0", c, a, rd1[c]); end
      end
      tick();
    end
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'h55; tick();
    clr = 1'b1; wr_data = 32'h77; rd_addr1 = 3'd4; #1;
    n_checks++; if (rd1[0] !== 32'h55) begin n_fail++; $display("FAIL clr_drops_bypass: got %h expected 55", rd1[0]); end
    tick(); idle_inputs(); #1;
    n_checks++; if (rdy[0] !== 1'b0 || rd1[0] !== 32'h55) begin n_fail++; $display("FAIL clr_drops_write: got %b/%h expected 0/55", rdy[0], rd1[0]); end
    for (int k = 0; k < D; k++) tick();
    #1;
    n_checks++; if (rdy[0] !== 1'b1 || rd1[0] !== 32'h0) begin n_fail++; $display("FAIL sweep_done: got %b/%h expected 1/0", rdy[0], rd1[0]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(99) != 0);
      clr      = ($urandom_range(19) == 0);
      wr_en    = $urandom_range(1);
      res_en   = ($urandom_range(2) == 0);
      wr_addr  = AW'($urandom_range(D - 1));
      res_addr = AW'($urandom_range(D - 1));
      rd_addr1 = ($urandom_range(2) == 0) ? wr_addr : AW'($urandom_range(D - 1));
      rd_addr2 = AW'($urandom_range(D - 1));
      wr_data  = $urandom;
      #1;
      if (reset) begin
        for (int c = 0; c < 3; c++) begin
          n_checks++; if (rd1[c] !== exp_rd(c, rd_addr1)) begin n_fail++; $display("FAIL rand_rdata1 dut%0d iter %0d: got %h expected %h", c, n, rd1[c], exp_rd(c, rd_addr1)); end
          n_checks++; if (rd2[c] !== exp_rd(c, rd_addr2)) begin n_fail++; $display("FAIL rand_rdata2 dut%0d iter %0d: got %h expected %h", c, n, rd2[c], exp_rd(c, rd_addr2)); end
          n_checks++; if (b1[c] !== exp_busy(c, rd_addr1) || b2[c] !== exp_busy(c, rd_addr2)) begin
            n_fail++; $display("FAIL rand_busy dut%0d iter %0d: got %b%b expected %b%b", c, n, b1[c], b2[c], exp_busy(c, rd_addr1), exp_busy(c, rd_addr2));
          end
          n_checks++; if (rdy[c] !== (sweep_pos < 0)) begin n_fail++; $display("FAIL rand_ready dut%0d iter %0d: got %b expected %b", c, n, rdy[c], sweep_pos < 0); end
        end
      end
      tick();
    end
    reset = 1'b1; idle_inputs();
  endtask

  initial begin
    reset = 1'b0; idle_inputs();
    wr_addr = '0; res_addr = '0; rd_addr1 = '0; rd_addr2 = '0; wr_data = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_busy();
    test_clear();
    test_zero_reg0();
    test_reset_mid_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
